// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM request arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default SDRAM byte-address and data widths (32 MB x8)
//   arb_state_t             : arbiter FSM states
//   timer_width()           : bits needed for a timer that counts 0..timeout
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   valid  : request vector
//   ptr    : index with highest priority this round
//   onehot : one-hot winner (zero when nothing is valid)
//   idx    : binary index of the winner (zero when nothing is valid)
// The winner is the first valid index >= ptr, wrapping back to 0.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    logic hit;

    // First pass looks at ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        onehot = '0;
        idx    = '0;
        hit    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!hit && valid[i] && (i >= int'(ptr))) begin
                hit       = 1'b1;
                idx       = IDX_W'(i);
                onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!hit && valid[i]) begin
                hit       = 1'b1;
                idx       = IDX_W'(i);
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Shares one SDRAM controller port between NUM_REQ requesters.
// Requester 0 has fixed priority, capped at PRIO_MAX consecutive grants while
// others wait; requesters 1..NUM_REQ-1 are served round-robin. One transaction
// is outstanding at a time; the response is routed back to its owner.
//
// Ports:
//   clock, rst_n              : system clock, async active-low reset
//   req_valid/rw/addr/wdata   : per-requester request (addr/wdata packed by index)
//   req_ack                   : one-cycle accept pulse to the winner
//   rsp_valid/rdata/err       : one-cycle completion pulse, read data, timeout flag
//   sd_valid/rw/addr/wdata    : command strobe and latched fields to the controller
//   sd_busy/done/rdata        : controller back-pressure, completion, read data
//   err                       : sticky timeout flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch the winner's fields
// ISSUE | strobe command to controller once sd_busy is low
// WAIT  | wait for sd_done or timeout, then respond to the winner
module sdram_req_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PRIO_MAX = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      sd_valid,
    output logic                      sd_rw,
    output logic [ADDR_W-1:0]         sd_addr,
    output logic [DATA_W-1:0]         sd_wdata,
    input  logic                      sd_busy,
    input  logic                      sd_done,
    input  logic [DATA_W-1:0]         sd_rdata,
    output logic                      err
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int RR_N    = NUM_REQ - 1;
    localparam int RR_W    = (RR_N > 1) ? $clog2(RR_N) : 1;
    localparam int PRIO_W  = $clog2(PRIO_MAX + 1);
    localparam int TIMER_W = timer_width(TIMEOUT);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PRIO_W-1:0]    prio_q, prio_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 rw_q, rw_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 err_q, err_d;

    logic [RR_N-1:0]      pick_onehot;
    logic [RR_W-1:0]      pick_idx;
    logic [RR_W-1:0]      pick_ptr;
    logic                 others_valid;
    logic                 grant0;
    logic [IDX_W-1:0]     win_next;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 sel_rw;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    // rr_ptr lives in 1..NUM_REQ-1; the picker works on the 0-based sub-vector.
    assign pick_ptr = RR_W'(rr_ptr_q - IDX_W'(1));

    rr_pick #(
        .N     (RR_N),
        .IDX_W (RR_W)
    ) u_rr_pick (
        .valid  (req_valid[NUM_REQ-1:1]),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // The picker produces a winner exactly when some requester 1..N-1 is valid.
    assign others_valid = |pick_onehot;
    assign grant0       = req_valid[0] && ((prio_q < PRIO_W'(PRIO_MAX)) || !others_valid);
    assign win_next     = grant0 ? '0 : (IDX_W'(pick_idx) + IDX_W'(1));
    assign win_onehot   = NUM_REQ'(1) << win_q;

    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_next == IDX_W'(i)) begin
                sel_rw    = req_rw[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        rr_ptr_d    = rr_ptr_q;
        prio_d      = prio_q;
        timer_d     = timer_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;
        err_d       = err_q;
        sd_valid    = 1'b0;
        req_ack     = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    win_d   = win_next;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (grant0) begin
                        if (prio_q != PRIO_W'(PRIO_MAX)) begin
                            prio_d = prio_q + PRIO_W'(1);
                        end
                    end else begin
                        prio_d = '0;
                        if (win_next == IDX_W'(NUM_REQ - 1)) begin
                            rr_ptr_d = IDX_W'(1);
                        end else begin
                            rr_ptr_d = win_next + IDX_W'(1);
                        end
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (!sd_busy) begin
                    sd_valid = 1'b1;
                    req_ack  = win_onehot;
                    timer_d  = '0;
                    state_d  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                timer_d = timer_q + TIMER_W'(1);
                // Completion takes precedence over a coincident timeout.
                if (sd_done) begin
                    rsp_valid_d = win_onehot;
                    rsp_rdata_d = sd_rdata;
                    state_d     = ST_IDLE;
                end else if (timer_q == TIMER_W'(TIMEOUT)) begin
                    rsp_valid_d = win_onehot;
                    rsp_err_d   = 1'b1;
                    err_d       = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            rr_ptr_q    <= IDX_W'(1);
            prio_q      <= '0;
            timer_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            rr_ptr_q    <= rr_ptr_d;
            prio_q      <= prio_d;
            timer_q     <= timer_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_q       <= err_d;
        end
    end

    assign sd_rw     = rw_q;
    assign sd_addr   = addr_q;
    assign sd_wdata  = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed testbench for sdram_req_arbiter (NUM_REQ=3, PRIO_MAX=4, TIMEOUT=255).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sdram_req_arbiter;

    localparam int NR = 3;
    localparam int AW = 25;
    localparam int DW = 8;

    logic             clock;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_rw;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ack;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err;
    logic             sd_valid;
    logic             sd_rw;
    logic [AW-1:0]    sd_addr;
    logic [DW-1:0]    sd_wdata;
    logic             sd_busy;
    logic             sd_done;
    logic [DW-1:0]    sd_rdata;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    sdram_req_arbiter #(
        .NUM_REQ  (NR),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .PRIO_MAX (4),
        .TIMEOUT  (255)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sd_valid  (sd_valid),
        .sd_rw     (sd_rw),
        .sd_addr   (sd_addr),
        .sd_wdata  (sd_wdata),
        .sd_busy   (sd_busy),
        .sd_done   (sd_done),
        .sd_rdata  (sd_rdata),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic clear_inputs;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_wdata = '0;
        sd_busy   = 1'b0;
        sd_done   = 1'b0;
        sd_rdata  = '0;
    endtask

    // Leaves the bench on a falling edge with reset just released.
    task automatic apply_reset;
        @(negedge clock);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for an ack, completes the transaction after 'delay'
    // cycles with read data 'rd', and returns what the DUT produced.
    task automatic serve(input int delay, input logic [DW-1:0] rd,
                         output logic [NR-1:0] ack_seen, output logic [NR-1:0] rsp_seen,
                         output logic err_seen, output logic [DW-1:0] rdata_seen);
        ack_seen = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (req_ack != '0) begin
                ack_seen = req_ack;
                break;
            end
        end
        repeat (delay - 1) @(negedge clock);
        sd_done  = 1'b1;
        sd_rdata = rd;
        @(negedge clock);
        sd_done    = 1'b0;
        rsp_seen   = rsp_valid;
        err_seen   = rsp_err;
        rdata_seen = rsp_rdata;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clock);
        n_cmp++;
        if ({sd_valid, req_ack, rsp_valid, rsp_rdata, rsp_err, sd_rw, sd_addr, sd_wdata, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ack=%b rsp=%b sd_valid=%b err=%b sd_addr=%h, want all zero",
                     req_ack, rsp_valid, sd_valid, err, sd_addr);
        end
        rst_n = 1'b1;
        @(negedge clock);
        sd_done  = 1'b1;
        sd_rdata = 8'hFF;
        @(negedge clock);
        sd_done = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_rdata, sd_valid} !== '0) begin
            n_bad++;
            $display("FAIL done_in_idle: rsp_valid=%b rsp_rdata=%h sd_valid=%b, want 0/00/0",
                     rsp_valid, rsp_rdata, sd_valid);
        end
    endtask

    task automatic test_single_read;
        logic early;
        apply_reset();
        req_addr[1*AW +: AW] = 25'h0001234;
        req_rw    = 3'b000;
        req_valid = 3'b010;
        @(negedge clock);
        n_cmp++;
        if ({req_ack, sd_valid, sd_rw, sd_addr} !== {3'b010, 1'b1, 1'b0, 25'h0001234}) begin
            n_bad++;
            $display("FAIL read_issue: ack=%b sd_valid=%b sd_rw=%b sd_addr=%h, want 010/1/0/0001234",
                     req_ack, sd_valid, sd_rw, sd_addr);
        end
        req_valid = '0;
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (rsp_valid !== '0 || sd_valid !== 1'b0 || sd_addr !== 25'h0001234) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL read_wait_quiet: spurious rsp/strobe or address change seen=%b, want 0", early);
        end
        sd_done  = 1'b1;
        sd_rdata = 8'hA5;
        @(negedge clock);
        sd_done = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_rdata, rsp_err, req_ack} !== {3'b010, 8'hA5, 1'b0, 3'b000}) begin
            n_bad++;
            $display("FAIL read_response: rsp=%b rdata=%h rsp_err=%b ack=%b, want 010/a5/0/000",
                     rsp_valid, rsp_rdata, rsp_err, req_ack);
        end
        @(negedge clock);
        n_cmp++;
        if (rsp_valid !== 3'b000) begin
            n_bad++;
            $display("FAIL read_rsp_pulse: rsp=%b one cycle later, want 000", rsp_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [NR-1:0] ack, rsp, exp;
        logic          e;
        logic [DW-1:0] rd, want_rd;
        apply_reset();
        req_valid = 3'b110;
        for (int k = 0; k < 4; k++) begin
            want_rd = 8'h10 + 8'(k);
            exp = (k % 2 == 0) ? 3'b010 : 3'b100;
            serve(3, want_rd, ack, rsp, e, rd);
            n_cmp++;
            if ({ack, rsp, e, rd} !== {exp, exp, 1'b0, want_rd}) begin
                n_bad++;
                $display("FAIL rr_grant_%0d: ack=%b rsp=%b err=%b rdata=%h, want %b/%b/0/%h",
                         k, ack, rsp, e, rd, exp, exp, want_rd);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_prio_cap;
        int            exp_q [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
        logic [NR-1:0] ack, rsp, exp;
        logic          e;
        logic [DW-1:0] rd;
        apply_reset();
        req_valid = 3'b111;
        for (int k = 0; k < 10; k++) begin
            exp = 3'b001 << exp_q[k];
            serve(2, 8'h00, ack, rsp, e, rd);
            n_cmp++;
            if ({ack, rsp} !== {exp, exp}) begin
                n_bad++;
                $display("FAIL prio_grant_%0d: ack=%b rsp=%b, want %b", k, ack, rsp, exp);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_busy_stall;
        logic bad;
        apply_reset();
        sd_busy = 1'b1;
        req_addr[2*AW +: AW]  = 25'h1555AAA;
        req_wdata[2*DW +: DW] = 8'hC3;
        req_rw    = 3'b100;
        req_valid = 3'b100;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (sd_valid !== 1'b0 || req_ack !== '0 || sd_addr !== 25'h1555AAA) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_hold: strobe/ack during busy or address unstable=%b, want 0", bad);
        end
        sd_busy = 1'b0;
        #1;
        n_cmp++;
        if ({sd_valid, req_ack, sd_rw, sd_wdata} !== {1'b1, 3'b100, 1'b1, 8'hC3}) begin
            n_bad++;
            $display("FAIL busy_release: sd_valid=%b ack=%b sd_rw=%b sd_wdata=%h, want 1/100/1/c3",
                     sd_valid, req_ack, sd_rw, sd_wdata);
        end
        @(negedge clock);
        req_valid = '0;
        n_cmp++;
        if ({sd_valid, req_ack, sd_addr} !== {1'b0, 3'b000, 25'h1555AAA}) begin
            n_bad++;
            $display("FAIL busy_single_pulse: sd_valid=%b ack=%b sd_addr=%h, want 0/000/1555aaa",
                     sd_valid, req_ack, sd_addr);
        end
        repeat (2) @(negedge clock);
        sd_done = 1'b1;
        @(negedge clock);
        sd_done = 1'b0;
        n_cmp++;
        if ({rsp_valid, rsp_err} !== {3'b100, 1'b0}) begin
            n_bad++;
            $display("FAIL busy_response: rsp=%b rsp_err=%b, want 100/0", rsp_valid, rsp_err);
        end
    endtask

    task automatic test_done_at_timeout;
        logic early;
        apply_reset();
        req_addr[1*AW +: AW] = 25'h0000042;
        req_valid = 3'b010;
        @(negedge clock);
        n_cmp++;
        if (req_ack !== 3'b010) begin
            n_bad++;
            $display("FAIL edge_issue: ack=%b, want 010", req_ack);
        end
        req_valid = '0;
        early = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            if (rsp_valid !== '0) early = 1'b1;
        end
        sd_done  = 1'b1;
        sd_rdata = 8'h99;
        @(negedge clock);
        sd_done = 1'b0;
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL edge_early_rsp: response before timer expiry=%b, want 0", early);
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, err, rsp_rdata} !== {3'b010, 1'b0, 1'b0, 8'h99}) begin
            n_bad++;
            $display("FAIL done_beats_timeout: rsp=%b rsp_err=%b err=%b rdata=%h, want 010/0/0/99",
                     rsp_valid, rsp_err, err, rsp_rdata);
        end
    endtask

    task automatic test_timeout;
        logic          early;
        logic [NR-1:0] ack, rsp;
        logic          e;
        logic [DW-1:0] rd;
        req_addr[0*AW +: AW]  = 25'h1FFFFFF;
        req_wdata[0*DW +: DW] = 8'h3C;
        req_rw    = 3'b001;
        req_valid = 3'b001;
        @(negedge clock);
        n_cmp++;
        if ({req_ack, sd_rw, sd_addr, sd_wdata} !== {3'b001, 1'b1, 25'h1FFFFFF, 8'h3C}) begin
            n_bad++;
            $display("FAIL to_issue: ack=%b sd_rw=%b sd_addr=%h sd_wdata=%h, want 001/1/1ffffff/3c",
                     req_ack, sd_rw, sd_addr, sd_wdata);
        end
        req_valid = '0;
        req_rw    = '0;
        early = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            if (rsp_valid !== '0 || err !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_bad++;
            $display("FAIL to_early: response or err before expiry=%b, want 0", early);
        end
        @(negedge clock);
        n_cmp++;
        if ({rsp_valid, rsp_err, err} !== {3'b001, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL to_response: rsp=%b rsp_err=%b err=%b, want 001/1/1", rsp_valid, rsp_err, err);
        end
        @(negedge clock);
        n_cmp++;
        if ({rsp_valid, rsp_err, err} !== {3'b000, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL to_sticky: rsp=%b rsp_err=%b err=%b, want 000/0/1", rsp_valid, rsp_err, err);
        end
        req_addr[1*AW +: AW] = 25'h0000777;
        req_valid = 3'b010;
        serve(3, 8'h5A, ack, rsp, e, rd);
        req_valid = '0;
        n_cmp++;
        if ({ack, rsp, e, rd, err} !== {3'b010, 3'b010, 1'b0, 8'h5A, 1'b1}) begin
            n_bad++;
            $display("FAIL to_next_normal: ack=%b rsp=%b rsp_err=%b rdata=%h err=%b, want 010/010/0/5a/1",
                     ack, rsp, e, rd, err);
        end
    endtask

    task automatic test_async_reset;
        logic [NR-1:0] ack, rsp;
        logic          e;
        logic [DW-1:0] rd;
        req_addr[1*AW +: AW]  = 25'h00ABCDE;
        req_wdata[1*DW +: DW] = 8'h77;
        req_rw    = 3'b010;
        req_valid = 3'b010;
        @(negedge clock);
        n_cmp++;
        if (req_ack !== 3'b010) begin
            n_bad++;
            $display("FAIL ar_issue: ack=%b, want 010", req_ack);
        end
        req_valid = '0;
        repeat (2) @(negedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sd_valid, req_ack, rsp_valid, rsp_rdata, rsp_err, sd_rw, sd_addr, sd_wdata, err} !== '0) begin
            n_bad++;
            $display("FAIL ar_outputs_zero: sd_rw=%b sd_addr=%h sd_wdata=%h err=%b rsp=%b, want all zero",
                     sd_rw, sd_addr, sd_wdata, err, rsp_valid);
        end
        @(negedge clock);
        sd_done = 1'b1;
        @(negedge clock);
        sd_done = 1'b0;
        rst_n   = 1'b1;
        req_rw  = '0;
        n_cmp++;
        if (rsp_valid !== 3'b000) begin
            n_bad++;
            $display("FAIL ar_no_response: rsp=%b, want 000", rsp_valid);
        end
        req_valid = 3'b110;
        serve(2, 8'h11, ack, rsp, e, rd);
        n_cmp++;
        if ({ack, rsp} !== {3'b010, 3'b010}) begin
            n_bad++;
            $display("FAIL ar_rr_ptr_reset: ack=%b rsp=%b, want 010/010", ack, rsp);
        end
        serve(2, 8'h22, ack, rsp, e, rd);
        req_valid = '0;
        n_cmp++;
        if ({ack, rsp} !== {3'b100, 3'b100}) begin
            n_bad++;
            $display("FAIL ar_second_grant: ack=%b rsp=%b, want 100/100", ack, rsp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_prio_cap();
        test_busy_stall();
        test_done_at_timeout();
        test_timeout();
        test_async_reset();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Shares the single 8-bit SDRAM controller port between NUM_REQ requesters, for example the HDMI framebuffer fetch, the CPU and the AVR/SPI loader.
- Requester 0 has fixed priority, with an anti-starvation cap. The remaining requesters are served round-robin.
- Sits between requester logic and the SDRAM controller. Issues one transaction at a time, waits for completion, then routes the response back to the owner.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- ADDR_W, 25: byte address width of the SDRAM (32 MB x8).
- DATA_W, 8: data width of the SDRAM.
- PRIO_MAX, 4: maximum consecutive grants to requester 0 while others are pending.
- TIMEOUT, 255: cycles to wait for sd_done before aborting.

Ports:
- clock  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester request; held until req_ack.
- req_rw  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ack  out  NUM_REQ  one-cycle pulse when the request is accepted.
- rsp_valid  out  NUM_REQ  one-cycle pulse when the transaction completes.
- rsp_rdata  out  DATA_W  read data; shared, qualified by rsp_valid.
- rsp_err  out  1  high together with rsp_valid when the transaction timed out.
- sd_valid  out  1  one-cycle command strobe to the controller.
- sd_rw  out  1  latched direction.
- sd_addr  out  ADDR_W  latched address.
- sd_wdata  out  DATA_W  latched write data.
- sd_busy  in  1  controller cannot accept a command.
- sd_done  in  1  one-cycle completion pulse from the controller.
- sd_rdata  in  DATA_W  read data, valid with sd_done.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0 and the FSM is in IDLE. rr_ptr=1, prio_cnt=0, timer=0.
- Reset mid-transaction: the operation is abandoned immediately with no response. The controller shares rst_n.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is set, compute winner combinationally and register winner, rw, addr and wdata. Go to ISSUE.
  - If no request, stay in IDLE.
- Arbitration:
  - Requester 0 wins if req_valid[0] and (prio_cnt<PRIO_MAX or no other req_valid).
  - Otherwise the winner is the first valid index >=rr_ptr among 1..NUM_REQ-1, wrapping from NUM_REQ-1 back to 1.
  - When 0 wins, prio_cnt increments, saturating at PRIO_MAX. When another requester wins, prio_cnt=0 and rr_ptr=winner+1, wrapping to 1.
- ISSUE:
  - While sd_busy=1, hold with no strobe.
  - On the first cycle with sd_busy=0: sd_valid=1 and req_ack[winner]=1 for exactly that cycle, timer cleared, go to WAIT.
  - sd_rw, sd_addr and sd_wdata stay stable from ISSUE entry until WAIT exits.
- WAIT:
  - The timer increments each cycle.
  - On sd_done: rsp_valid[winner]=1 next cycle. rsp_rdata takes sd_rdata, registered; it is valid for reads and don't-care for writes. Go to IDLE.
  - If timer reaches TIMEOUT before sd_done: rsp_valid[winner]=1 with rsp_err=1, err is set, go to IDLE.
- Latency: req_valid seen in IDLE at cycle t gives sd_valid and req_ack at t+1 (sd_busy=0). sd_done at cycle d gives rsp_valid at d+1.
- The FSM spends at least one cycle in IDLE between transactions.
- Boundary conditions:
  - sd_done outside WAIT is ignored.
  - sd_done and timeout in the same cycle: done wins, no error.
  - A new req_valid during ISSUE/WAIT waits; at most one transaction is outstanding.
  - A request dropped before ack after grant still completes, because its fields are latched.
  - NUM_REQ=2 gives no round-robin; the round-robin field is constant 1.
- rsp_valid and req_ack are one-hot or zero at all times.

Decomposition:
- Package sdram_arb_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the FSM state enum (IDLE/ISSUE/WAIT);
  - the timer width, clog2(TIMEOUT+1).
- Sub-module rr_pick: combinational rotating-priority picker. Inputs are the valid vector and the pointer; outputs are the one-hot and index of the winner. It is reused by the later HDMI-in buffer arbiter.

Test Plan:
1. Single read: req_valid[1], addr 0x0001234, sd_busy=0, sd_done 5 cycles after sd_valid with sd_rdata=0xA5 -> req_ack[1] at t+1; sd_addr=0x0001234, sd_rw=0; rsp_valid[1] with rsp_rdata=0xA5 at done+1; no other bits set.
2. Round-robin: req_valid[1] and req_valid[2] held constantly, requester 0 idle -> grants alternate 1,2,1,2 over 4 transactions; rr_ptr wraps correctly.
3. Priority cap: all three requesters held, PRIO_MAX=4 -> grant order 0,0,0,0,1,0,0,0,0,2.
4. Busy stall: sd_busy=1 for 10 cycles after grant -> sd_valid and req_ack stay 0; both pulse once on the first cycle with sd_busy=0; sd_addr stable throughout.
5. Timeout: write with sd_done never asserted, TIMEOUT=255 -> rsp_valid[w]=1 and rsp_err=1 about 256 cycles after sd_valid; err stays 1; the next request is served normally.
6. Async reset in WAIT: pull rst_n low mid-transaction -> all outputs 0 in the same cycle; after release, the first request of requester 2 is granted with rr_ptr=1 semantics (requester 1 first if both valid).
